// File: rtl/snake_pkg.sv
// snake_pkg: shared snake game constants and the collision FSM state type.
package snake_pkg;
  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int MAX_LEN = 100;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {IDLE, WALL, SCAN, WAIT, REPORT} state_e;
endpackage

// File: rtl/collision_detector.sv
// collision_detector: checks a freshly moved snake head against walls, its own body and the apple.
// Body memory is read-synchronous: data for bodyIdx arrives one cycle later, so SCAN compares index i-1.
module collision_detector
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             nRst,
  input  logic             step,
  input  logic [3:0]       headX,
  input  logic [3:0]       headY,
  input  logic [3:0]       appleX,
  input  logic [3:0]       appleY,
  input  logic [LEN_W-1:0] snakeLen,
  output logic [LEN_W-1:0] bodyIdx,
  input  logic [3:0]       bodyX,
  input  logic [3:0]       bodyY,
  output logic             goodColl,
  output logic             badColl,
  output logic             busy
);
  state_e state_q, state_d;
  logic [3:0] hx_q, hx_d, hy_q, hy_d, ax_q, ax_d, ay_q, ay_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic bad_q, bad_d, good_q, good_d;
  logic good_coll_q, good_coll_d, bad_coll_q, bad_coll_d, busy_q, busy_d;
  logic cap, wall, hit;
  assign cap = state_q == IDLE && step;
  assign wall = int'(hx_q) >= GRID_W || int'(hy_q) >= GRID_H;
  assign hit = bodyX == hx_q && bodyY == hy_q;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      hx_q <= '0;
      hy_q <= '0;
      ax_q <= '0;
      ay_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      bad_q <= 1'b0;
      good_q <= 1'b0;
      good_coll_q <= 1'b0;
      bad_coll_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      len_q <= len_d;
      idx_q <= idx_d;
      bad_q <= bad_d;
      good_q <= good_d;
      good_coll_q <= good_coll_d;
      bad_coll_q <= bad_coll_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = step ? WALL : IDLE;
      WALL:    state_d = (wall || len_q <= LEN_W'(1)) ? REPORT : SCAN;
      SCAN:    state_d = (idx_q > LEN_W'(1) && hit) ? REPORT : (idx_q == len_q - LEN_W'(1)) ? WAIT : SCAN;
      WAIT:    state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    hx_d = cap ? headX : hx_q;
    hy_d = cap ? headY : hy_q;
    ax_d = cap ? appleX : ax_q;
    ay_d = cap ? appleY : ay_q;
    len_d = cap ? snakeLen : len_q;
    idx_d = state_d != SCAN ? '0 : state_q == WALL ? LEN_W'(1) : idx_q + LEN_W'(1);
    bad_d = state_q != IDLE && (bad_q || (state_q == WALL && wall) ||
            (state_q == SCAN && idx_q > LEN_W'(1) && hit) || (state_q == WAIT && hit));
    good_d = state_q != IDLE && (good_q || (state_q == WALL && hx_q == ax_q && hy_q == ay_q));
  end
  always_comb begin
    bad_coll_d = state_q == REPORT && bad_q;
    good_coll_d = state_q == REPORT && !bad_q && good_q;
    busy_d = state_d != IDLE;
  end
  assign bodyIdx = idx_q;
  assign goodColl = good_coll_q;
  assign badColl = bad_coll_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed scenarios against a synchronous-read body memory model.
module tb_collision_detector;
  logic clk = 1'b0, nRst = 1'b0, step = 1'b0;
  logic [3:0] headX = '0, headY = '0, appleX = '0, appleY = '0, bodyX = '0, bodyY = '0;
  logic [6:0] snakeLen = 7'd1, bodyIdx;
  logic goodColl, badColl, busy;
  logic [3:0] mx [0:127];
  logic [3:0] my [0:127];
  int nvec = 0, nerr = 0;
  int busy_cnt, good_cnt, bad_cnt, good_at, bad_at;
  int idx_seq [$];

  collision_detector dut (
    .clk(clk), .nRst(nRst), .step(step), .headX(headX), .headY(headY),
    .appleX(appleX), .appleY(appleY), .snakeLen(snakeLen), .bodyIdx(bodyIdx),
    .bodyX(bodyX), .bodyY(bodyY), .goodColl(goodColl), .badColl(badColl), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bodyX <= mx[bodyIdx];
    bodyY <= my[bodyIdx];
  end

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the caller #1 after the edge that captured the step (first busy cycle);
  // then scrambles the inputs so any leak past the latch shows up.
  task automatic do_step(input int hx, input int hy, input int ax, input int ay, input int len);
    @(negedge clk);
    headX = 4'(hx); headY = 4'(hy); appleX = 4'(ax); appleY = 4'(ay); snakeLen = 7'(len);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    headX = headX ^ 4'h5;
    appleY = appleY ^ 4'h3;
    snakeLen = 7'd1;
  endtask

  task automatic observe(input int n, input int step2_at);
    busy_cnt = 0; good_cnt = 0; bad_cnt = 0; good_at = -1; bad_at = -1;
    idx_seq.delete();
    for (int c = 1; c <= n; c++) begin
      if (busy) busy_cnt++;
      if (goodColl) begin good_cnt++; if (good_at < 0) good_at = c; end
      if (badColl) begin bad_cnt++; if (bad_at < 0) bad_at = c; end
      if (bodyIdx != 0) idx_seq.push_back(int'(bodyIdx));
      if (c == step2_at) begin
        step = 1'b1; headX = 4'hf; headY = 4'hf;
      end else step = 1'b0;
      @(posedge clk);
      #1;
    end
    step = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin mx[i] = 4'hf; my[i] = 4'hf; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_good", int'(goodColl), 0);
    chk("rst_bad", int'(badColl), 0);
    chk("rst_idx", int'(bodyIdx), 0);
    @(negedge clk) nRst = 1'b1;

    // reset mid-check with step held high aborts without a pulse
    do_step(4, 4, 4, 4, 1);
    step = 1'b1; nRst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_good", int'(goodColl), 0);
    chk("abort_bad", int'(badColl), 0);
    chk("abort_idx", int'(bodyIdx), 0);
    @(negedge clk);
    nRst = 1'b1; step = 1'b0;
    observe(6, 0);
    chk("abort_pulses", good_cnt + bad_cnt, 0);

    do_step(3, 3, 3, 3, 1);
    observe(8, 0);
    chk("apple_good_cnt", good_cnt, 1);
    chk("apple_good_at", good_at, 3);
    chk("apple_bad_cnt", bad_cnt, 0);
    chk("apple_busy", busy_cnt, 2);

    do_step(5, 12, 0, 0, 1);
    observe(8, 0);
    chk("wall_bad_cnt", bad_cnt, 1);
    chk("wall_bad_at", bad_at, 3);
    chk("wall_good_cnt", good_cnt, 0);

    mx[0] = 4'd2; my[0] = 4'd2; mx[1] = 4'd2; my[1] = 4'd3;
    mx[2] = 4'd2; my[2] = 4'd4; mx[3] = 4'd2; my[3] = 4'd5;
    do_step(2, 2, 9, 9, 4);
    observe(10, 0);
    chk("scan_idx_len", idx_seq.size(), 3);
    if (idx_seq.size() == 3) begin
      chk("scan_idx0", idx_seq[0], 1);
      chk("scan_idx1", idx_seq[1], 2);
      chk("scan_idx2", idx_seq[2], 3);
    end
    chk("scan_busy", busy_cnt, 6);
    chk("scan_pulses", good_cnt + bad_cnt, 0);

    my[2] = 4'd2;
    do_step(2, 2, 2, 2, 4);
    observe(10, 0);
    chk("self_bad_cnt", bad_cnt, 1);
    chk("self_good_cnt", good_cnt, 0);
    chk("self_bad_at", bad_at, 6);
    chk("self_busy", busy_cnt, 5);

    // second step lands during REPORT with wall-hitting inputs; it must be dropped
    do_step(3, 3, 3, 3, 1);
    observe(12, 2);
    chk("dbl_good_cnt", good_cnt, 1);
    chk("dbl_bad_cnt", bad_cnt, 0);
    chk("dbl_busy", busy_cnt, 2);

    for (int i = 0; i < 10; i++) begin mx[i] = 4'(i); my[i] = 4'd11; end
    do_step(8, 8, 1, 1, 10);
    observe(4, 0);
    chk("mid_scan_idx", int'(bodyIdx), 4);
    nRst = 1'b0;
    #1;
    chk("scanrst_idx", int'(bodyIdx), 0);
    chk("scanrst_busy", int'(busy), 0);
    @(negedge clk) nRst = 1'b1;
    observe(15, 0);
    chk("scanrst_pulses", good_cnt + bad_cnt, 0);
    chk("scanrst_busy_after", busy_cnt, 0);

    do_step(7, 7, 7, 7, 1);
    observe(8, 0);
    chk("post_good_cnt", good_cnt, 1);
    chk("post_good_at", good_at, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
